hazard_ctrl_v2: RTL and testbench
=================================

Name: hazard_ctrl_v2

Overview:
Second-generation hazard/stall/flush controller for the 5-stage MIPS pipeline. It splits the cache stall into separate I-side and D-side stalls, and it latches a branch/jump redirect that arrives while fetch is blocked, replaying it once fetch is free. It also tracks a multi-cycle mul/div unit, suppresses false load-use stalls on $zero, and exposes saturating performance counters. Stage-enable outputs are combinational from the inputs plus registered state; everything else is clocked.

Parameters:
ADDR_W, 32, width of PC and redirect addresses
REG_W, 5, register-specifier width
MULDIV_CYCLES, 4, busy cycles after a mul/div issue (>=1)
PERF_W, 32, performance counter width

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
pc_write_en  out  1  PC update enable
pc_redirect  out  1  PC load from pc_redirect_addr
pc_redirect_addr  out  ADDR_W  redirect target
if_id_rs, if_id_rt  in  REG_W each  source registers of the ID instruction
id_jump  in  1  ID holds J/JAL/JR
id_jump_target  in  ADDR_W  jump target
id_is_muldiv  in  1  ID instruction is MULT/DIV
id_reads_hilo  in  1  ID instruction is MFHI/MFLO
if_id_write_en, if_id_flush_en  out  1 each  IF/ID register control
id_ex_rt  in  REG_W  destination of the EX load
id_ex_mem_read  in  1  EX holds a load
ex_branch_valid  in  1  EX holds a resolved branch
id_ex_pred_taken, ex_branch_taken  in  1 each  predicted / actual outcome
ex_branch_target, ex_pc_plus4  in  ADDR_W each  redirect candidates
ex_muldiv_start  in  1  a mul/div leaves EX this cycle
id_ex_write_en, id_ex_flush_en  out  1 each  ID/EX register control
icache_stall, dcache_stall  in  1 each  cache miss stalls
ex_mem_write_en, ex_mem_flush_en, mem_wb_write_en  out  1 each  later stage controls
muldiv_busy  out  1  mul/div counter non-zero
perf_clear  in  1  synchronous counter clear
perf_stall_cycles, perf_mispredicts  out  PERF_W each  saturating counters

Behaviour:
- **Reset state (rst_n=0 at an edge):** pend_valid=0, pend_addr=0, muldiv_cnt=0, both perf counters=0.
- **Outputs while rst_n=0:** every *_write_en=0, every *_flush_en=1, pc_redirect=0, pc_redirect_addr=0.
- **Defaults:** all write_en=1, all flush_en=0, pc_redirect=0, pc_redirect_addr=0.
- **mispredict** = ex_branch_valid && (ex_branch_taken != id_ex_pred_taken).
- **mispredict target** = ex_branch_taken ? ex_branch_target : ex_pc_plus4.
- **load_use** = id_ex_mem_read && id_ex_rt!=0 && (id_ex_rt==if_id_rs || id_ex_rt==if_id_rt).
- **muldiv_haz** = muldiv_busy && (id_is_muldiv || id_reads_hilo).
- **Combinational priority, highest first:**
  1. dcache_stall: all five write_en=0, no flush, no redirect. Pending redirect is held. Mispredict is deferred, because EX is frozen and the condition persists.
  2. mispredict: flush IF/ID, ID/EX and EX/MEM.
     - If !icache_stall: pc_redirect=1 with the mispredict target; pending redirect is cleared.
     - If icache_stall: pc_write_en=0; pend_valid<=1 and pend_addr<=target. This overwrites any older pending redirect.
  3. pend_valid:
     - If icache_stall: pc_write_en=0, if_id_flush_en=1.
     - If !icache_stall: pc_redirect=1 with pend_addr, if_id_flush_en=1, pend_valid<=0.
  4. id_jump: if_id_flush_en=1.
     - If !icache_stall: pc_redirect=1 with id_jump_target.
     - If icache_stall: pc_write_en=0; pend_valid<=1 and pend_addr<=id_jump_target.
  5. icache_stall: pc_write_en=0, if_id_write_en=0, id_ex_flush_en=1 (bubble).
  6. load_use || muldiv_haz: pc_write_en=0, if_id_write_en=0, id_ex_flush_en=1.
- **Redirect latency:** a redirect deferred by icache_stall is issued in the first cycle icache_stall=0 with no dcache_stall and no mispredict. A mispredict in that cycle wins.
- **Mul/div counter:**
  - ex_muldiv_start: muldiv_cnt<=MULDIV_CYCLES.
  - Otherwise, if non-zero, it decrements by 1 every cycle, including during cache stalls.
  - muldiv_busy = (muldiv_cnt!=0).
  - Result: a dependent instruction sitting in ID in the cycle after start stalls exactly MULDIV_CYCLES cycles.
- **Perf counters:**
  - perf_clear zeroes both counters and overrides increments.
  - perf_stall_cycles +1 on every non-reset cycle with pc_write_en=0.
  - perf_mispredicts +1 on every cycle in which priority 2 is taken.
  - Both saturate at all-ones; no wrap.

Test Plan:
- Load-use: id_ex_mem_read=1, id_ex_rt=8, if_id_rs=8 -> pc_write_en=0, if_id_write_en=0, id_ex_flush_en=1 for 1 cycle. Repeat with id_ex_rt=0 -> no stall.
- Mispredict: ex_branch_valid=1, pred=0, taken=1, target=0x100 -> pc_redirect=1 with addr 0x100, three flushes, perf_mispredicts 0->1.
- Deferred redirect: icache_stall=1 for 3 cycles; mispredict with pred=1, taken=0, pc_plus4=0x44 in cycle 1 -> no pc_redirect for 3 cycles, if_id_flush_en=1 throughout; cycle icache_stall falls -> pc_redirect=1 with addr 0x44, then pend cleared.
- Mul/div: MULDIV_CYCLES=4, ex_muldiv_start pulse, then id_reads_hilo=1 -> exactly 4 stall cycles, then release. Restart mid-count reloads 4.
- D-cache priority: dcache_stall=1 together with mispredict -> all write_en=0, no redirect; on release the redirect is issued.
- Saturation and reset: PERF_W=4 with 20 stall cycles -> perf_stall_cycles=15. rst_n=0 one cycle with pend_valid=1 -> pend cleared, counters 0.

Source files
------------

// File: rtl/hazard_ctrl_v2.sv
// Hazard, stall and flush controller for a 5-stage MIPS pipeline.
// Split I/D cache stalls, a replay latch for redirects that hit a blocked
// fetch, a multi-cycle mul/div busy tracker and saturating perf counters.
module hazard_ctrl_v2 #(
  parameter int ADDR_W        = 32,
  parameter int REG_W         = 5,
  parameter int MULDIV_CYCLES = 4,
  parameter int PERF_W        = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              pc_write_en,
  output logic              pc_redirect,
  output logic [ADDR_W-1:0] pc_redirect_addr,
  input  logic [REG_W-1:0]  if_id_rs,
  input  logic [REG_W-1:0]  if_id_rt,
  input  logic              id_jump,
  input  logic [ADDR_W-1:0] id_jump_target,
  input  logic              id_is_muldiv,
  input  logic              id_reads_hilo,
  output logic              if_id_write_en,
  output logic              if_id_flush_en,
  input  logic [REG_W-1:0]  id_ex_rt,
  input  logic              id_ex_mem_read,
  input  logic              ex_branch_valid,
  input  logic              id_ex_pred_taken,
  input  logic              ex_branch_taken,
  input  logic [ADDR_W-1:0] ex_branch_target,
  input  logic [ADDR_W-1:0] ex_pc_plus4,
  input  logic              ex_muldiv_start,
  output logic              id_ex_write_en,
  output logic              id_ex_flush_en,
  input  logic              icache_stall,
  input  logic              dcache_stall,
  output logic              ex_mem_write_en,
  output logic              ex_mem_flush_en,
  output logic              mem_wb_write_en,
  output logic              muldiv_busy,
  input  logic              perf_clear,
  output logic [PERF_W-1:0] perf_stall_cycles,
  output logic [PERF_W-1:0] perf_mispredicts
);

  localparam int CNT_W = $clog2(MULDIV_CYCLES + 1);

  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [CNT_W-1:0]  muldiv_cnt_q, muldiv_cnt_d;
  logic [PERF_W-1:0] perf_stall_q, perf_stall_d;
  logic [PERF_W-1:0] perf_misp_q, perf_misp_d;
  logic              misp_taken;

  logic              mispredict;
  logic [ADDR_W-1:0] misp_target;
  logic              load_use;
  logic              muldiv_haz;

  assign mispredict  = ex_branch_valid && (ex_branch_taken != id_ex_pred_taken);
  assign misp_target = ex_branch_taken ? ex_branch_target : ex_pc_plus4;
  assign load_use    = id_ex_mem_read && (id_ex_rt != '0) &&
                       ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));
  assign muldiv_busy = (muldiv_cnt_q != '0);
  assign muldiv_haz  = muldiv_busy && (id_is_muldiv || id_reads_hilo);

  assign perf_stall_cycles = perf_stall_q;
  assign perf_mispredicts  = perf_misp_q;

  // Prioritised stage control; a redirect that cannot fetch is parked in pend.
  always_comb begin
    pc_write_en      = 1'b1;
    pc_redirect      = 1'b0;
    pc_redirect_addr = '0;
    if_id_write_en   = 1'b1;
    if_id_flush_en   = 1'b0;
    id_ex_write_en   = 1'b1;
    id_ex_flush_en   = 1'b0;
    ex_mem_write_en  = 1'b1;
    ex_mem_flush_en  = 1'b0;
    mem_wb_write_en  = 1'b1;
    pend_valid_d     = pend_valid_q;
    pend_addr_d      = pend_addr_q;
    misp_taken       = 1'b0;
    if (!rst_n) begin
      pc_write_en     = 1'b0;
      if_id_write_en  = 1'b0;
      id_ex_write_en  = 1'b0;
      ex_mem_write_en = 1'b0;
      mem_wb_write_en = 1'b0;
      if_id_flush_en  = 1'b1;
      id_ex_flush_en  = 1'b1;
      ex_mem_flush_en = 1'b1;
    end else if (dcache_stall) begin
      // Whole pipe frozen; a mispredict in EX persists and is taken on release.
      pc_write_en     = 1'b0;
      if_id_write_en  = 1'b0;
      id_ex_write_en  = 1'b0;
      ex_mem_write_en = 1'b0;
      mem_wb_write_en = 1'b0;
    end else if (mispredict) begin
      misp_taken      = 1'b1;
      if_id_flush_en  = 1'b1;
      id_ex_flush_en  = 1'b1;
      ex_mem_flush_en = 1'b1;
      if (!icache_stall) begin
        pc_redirect      = 1'b1;
        pc_redirect_addr = misp_target;
        pend_valid_d     = 1'b0;
      end else begin
        pc_write_en  = 1'b0;
        pend_valid_d = 1'b1;
        pend_addr_d  = misp_target;
      end
    end else if (pend_valid_q) begin
      if_id_flush_en = 1'b1;
      if (icache_stall) begin
        pc_write_en = 1'b0;
      end else begin
        pc_redirect      = 1'b1;
        pc_redirect_addr = pend_addr_q;
        pend_valid_d     = 1'b0;
      end
    end else if (id_jump) begin
      if_id_flush_en = 1'b1;
      if (!icache_stall) begin
        pc_redirect      = 1'b1;
        pc_redirect_addr = id_jump_target;
      end else begin
        pc_write_en  = 1'b0;
        pend_valid_d = 1'b1;
        pend_addr_d  = id_jump_target;
      end
    end else if (icache_stall) begin
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      id_ex_flush_en = 1'b1;
    end else if (load_use || muldiv_haz) begin
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      id_ex_flush_en = 1'b1;
    end
  end

  // Mul/div countdown and saturating performance counters.
  always_comb begin
    muldiv_cnt_d = muldiv_cnt_q;
    if (ex_muldiv_start) begin
      muldiv_cnt_d = CNT_W'(MULDIV_CYCLES);
    end else if (muldiv_cnt_q != '0) begin
      muldiv_cnt_d = muldiv_cnt_q - 1'b1;
    end
    perf_stall_d = perf_stall_q;
    perf_misp_d  = perf_misp_q;
    if (perf_clear) begin
      perf_stall_d = '0;
      perf_misp_d  = '0;
    end else begin
      if (!pc_write_en && !(&perf_stall_q)) perf_stall_d = perf_stall_q + 1'b1;
      if (misp_taken && !(&perf_misp_q))    perf_misp_d  = perf_misp_q + 1'b1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      muldiv_cnt_q <= '0;
      perf_stall_q <= '0;
      perf_misp_q  <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      muldiv_cnt_q <= muldiv_cnt_d;
      perf_stall_q <= perf_stall_d;
      perf_misp_q  <= perf_misp_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_v2.sv
// Scoreboard bench for hazard_ctrl_v2: a driver issues one stimulus per
// cycle and queues the reference model's expected response; a monitor pops
// and compares on the falling edge.
module tb_hazard_ctrl_v2;

  localparam int ADDR_W = 32;
  localparam int REG_W  = 5;
  localparam int MDC    = 4;
  localparam int PERF_W = 4;
  localparam int PMAX   = (1 << PERF_W) - 1;

  logic              clk;
  logic              rst_n;
  logic              pc_write_en, pc_redirect;
  logic [ADDR_W-1:0] pc_redirect_addr;
  logic [REG_W-1:0]  if_id_rs, if_id_rt, id_ex_rt;
  logic              id_jump, id_is_muldiv, id_reads_hilo;
  logic [ADDR_W-1:0] id_jump_target;
  logic              if_id_write_en, if_id_flush_en;
  logic              id_ex_mem_read, ex_branch_valid, id_ex_pred_taken, ex_branch_taken;
  logic [ADDR_W-1:0] ex_branch_target, ex_pc_plus4;
  logic              ex_muldiv_start;
  logic              id_ex_write_en, id_ex_flush_en;
  logic              icache_stall, dcache_stall;
  logic              ex_mem_write_en, ex_mem_flush_en, mem_wb_write_en;
  logic              muldiv_busy, perf_clear;
  logic [PERF_W-1:0] perf_stall_cycles, perf_mispredicts;

  hazard_ctrl_v2 #(.ADDR_W(ADDR_W), .REG_W(REG_W), .MULDIV_CYCLES(MDC), .PERF_W(PERF_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .pc_write_en(pc_write_en), .pc_redirect(pc_redirect), .pc_redirect_addr(pc_redirect_addr),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .id_jump(id_jump), .id_jump_target(id_jump_target),
    .id_is_muldiv(id_is_muldiv), .id_reads_hilo(id_reads_hilo),
    .if_id_write_en(if_id_write_en), .if_id_flush_en(if_id_flush_en),
    .id_ex_rt(id_ex_rt), .id_ex_mem_read(id_ex_mem_read),
    .ex_branch_valid(ex_branch_valid), .id_ex_pred_taken(id_ex_pred_taken),
    .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
    .ex_pc_plus4(ex_pc_plus4), .ex_muldiv_start(ex_muldiv_start),
    .id_ex_write_en(id_ex_write_en), .id_ex_flush_en(id_ex_flush_en),
    .icache_stall(icache_stall), .dcache_stall(dcache_stall),
    .ex_mem_write_en(ex_mem_write_en), .ex_mem_flush_en(ex_mem_flush_en),
    .mem_wb_write_en(mem_wb_write_en), .muldiv_busy(muldiv_busy),
    .perf_clear(perf_clear),
    .perf_stall_cycles(perf_stall_cycles), .perf_mispredicts(perf_mispredicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    bit          pc_we, pc_red;
    logic [31:0] addr;
    bit          ifid_we, ifid_fl, idex_we, idex_fl, exmem_we, exmem_fl, memwb_we, busy;
    int          stall, misp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   txn    = 0;

  // Reference model state: a pending-redirect slot, busy cycles left, counts.
  bit          m_pend;
  logic [31:0] m_pend_addr;
  int          m_md_left;
  int          m_stall, m_misp;

  task automatic chk(input string name, input int id, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL txn %0d %s: got 0x%0h expected 0x%0h", id, name, act, exp);
    end
  endtask

  task automatic idle();
    rst_n = 1'b1; if_id_rs = '0; if_id_rt = '0; id_ex_rt = '0;
    id_jump = 0; id_jump_target = '0; id_is_muldiv = 0; id_reads_hilo = 0;
    id_ex_mem_read = 0; ex_branch_valid = 0; id_ex_pred_taken = 0; ex_branch_taken = 0;
    ex_branch_target = '0; ex_pc_plus4 = '0; ex_muldiv_start = 0;
    icache_stall = 0; dcache_stall = 0; perf_clear = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Work out what the pipeline must do this cycle from the rule list, queue
  // it, then advance the model to the state after the coming clock edge.
  task automatic issue();
    exp_t        e;
    bit          misp, lu, hz, stall_pc, took_misp;
    logic [31:0] tgt;
    misp = ex_branch_valid && (ex_branch_taken != id_ex_pred_taken);
    tgt  = ex_branch_taken ? ex_branch_target : ex_pc_plus4;
    lu   = id_ex_mem_read && id_ex_rt != 0 && (id_ex_rt == if_id_rs || id_ex_rt == if_id_rt);
    hz   = (m_md_left > 0) && (id_is_muldiv || id_reads_hilo);
    e = '{id: txn, pc_we: 1, pc_red: 0, addr: 0, ifid_we: 1, ifid_fl: 0, idex_we: 1,
          idex_fl: 0, exmem_we: 1, exmem_fl: 0, memwb_we: 1, busy: (m_md_left > 0),
          stall: m_stall, misp: m_misp};
    took_misp = 0;
    if (!rst_n) begin
      e.pc_we = 0; e.ifid_we = 0; e.idex_we = 0; e.exmem_we = 0; e.memwb_we = 0;
      e.ifid_fl = 1; e.idex_fl = 1; e.exmem_fl = 1;
    end else if (dcache_stall) begin
      e.pc_we = 0; e.ifid_we = 0; e.idex_we = 0; e.exmem_we = 0; e.memwb_we = 0;
    end else if (misp) begin
      took_misp = 1;
      e.ifid_fl = 1; e.idex_fl = 1; e.exmem_fl = 1;
      if (icache_stall) begin e.pc_we = 0; m_pend = 1; m_pend_addr = tgt; end
      else begin e.pc_red = 1; e.addr = tgt; m_pend = 0; end
    end else if (m_pend) begin
      e.ifid_fl = 1;
      if (icache_stall) e.pc_we = 0;
      else begin e.pc_red = 1; e.addr = m_pend_addr; m_pend = 0; end
    end else if (id_jump) begin
      e.ifid_fl = 1;
      if (icache_stall) begin e.pc_we = 0; m_pend = 1; m_pend_addr = id_jump_target; end
      else begin e.pc_red = 1; e.addr = id_jump_target; end
    end else if (icache_stall || lu || hz) begin
      e.pc_we = 0; e.ifid_we = 0; e.idex_fl = 1;
    end
    sb.push_back(e);
    stall_pc = !e.pc_we;
    if (!rst_n) begin
      m_pend = 0; m_pend_addr = 0; m_md_left = 0; m_stall = 0; m_misp = 0;
    end else begin
      if (ex_muldiv_start) m_md_left = MDC;
      else if (m_md_left > 0) m_md_left--;
      if (perf_clear) begin
        m_stall = 0; m_misp = 0;
      end else begin
        if (stall_pc) m_stall = (m_stall < PMAX) ? m_stall + 1 : PMAX;
        if (took_misp) m_misp = (m_misp < PMAX) ? m_misp + 1 : PMAX;
      end
    end
    txn++;
  endtask

  // Monitor: the controller answers every cycle, so each falling edge with a
  // queued expectation is one transaction.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      int   err0;
      e    = sb.pop_front();
      err0 = errors;
      chk("pc_write_en", e.id, pc_write_en, e.pc_we);
      chk("pc_redirect", e.id, pc_redirect, e.pc_red);
      chk("pc_redirect_addr", e.id, pc_redirect_addr, e.addr);
      chk("if_id_write_en", e.id, if_id_write_en, e.ifid_we);
      chk("if_id_flush_en", e.id, if_id_flush_en, e.ifid_fl);
      chk("id_ex_write_en", e.id, id_ex_write_en, e.idex_we);
      chk("id_ex_flush_en", e.id, id_ex_flush_en, e.idex_fl);
      chk("ex_mem_write_en", e.id, ex_mem_write_en, e.exmem_we);
      chk("ex_mem_flush_en", e.id, ex_mem_flush_en, e.exmem_fl);
      chk("mem_wb_write_en", e.id, mem_wb_write_en, e.memwb_we);
      chk("muldiv_busy", e.id, muldiv_busy, e.busy);
      chk("perf_stall_cycles", e.id, perf_stall_cycles, e.stall);
      chk("perf_mispredicts", e.id, perf_mispredicts, e.misp);
      $display("txn %0d pc_we=%0d red=%0d addr=0x%0h stall=%0d misp=%0d %s", e.id,
               pc_write_en, pc_redirect, pc_redirect_addr, perf_stall_cycles,
               perf_mispredicts, (errors == err0) ? "ok" : "bad");
    end
  end

  initial begin
    idle();
    rst_n = 1'b0;
    m_pend = 0; m_pend_addr = 0; m_md_left = 0; m_stall = 0; m_misp = 0;
    cyc();                       // first edge resets the DUT

    // Outputs while held in reset.
    rst_n = 1'b0; issue(); cyc();

    // Load-use on rs, then the same load targeting $zero (no stall).
    idle(); id_ex_mem_read = 1; id_ex_rt = 5'd8; if_id_rs = 5'd8; issue(); cyc();
    idle(); issue(); cyc();
    idle(); id_ex_mem_read = 1; id_ex_rt = 5'd0; issue(); cyc();

    // Mispredict: predicted not-taken, taken to 0x100.
    idle(); ex_branch_valid = 1; ex_branch_taken = 1; ex_branch_target = 32'h100; issue(); cyc();
    idle(); issue(); cyc();

    // Mispredict under a 3-cycle I-cache stall, replayed on release.
    idle(); icache_stall = 1; ex_branch_valid = 1; id_ex_pred_taken = 1; ex_pc_plus4 = 32'h44;
    issue(); cyc();
    for (int i = 0; i < 2; i++) begin idle(); icache_stall = 1; issue(); cyc(); end
    for (int i = 0; i < 2; i++) begin idle(); issue(); cyc(); end

    // Mul/div: start, dependent MFHI held in ID, then a mid-count restart.
    idle(); ex_muldiv_start = 1; issue(); cyc();
    for (int i = 0; i < 6; i++) begin idle(); id_reads_hilo = 1; issue(); cyc(); end
    idle(); ex_muldiv_start = 1; issue(); cyc();
    for (int i = 0; i < 2; i++) begin idle(); id_is_muldiv = 1; issue(); cyc(); end
    idle(); ex_muldiv_start = 1; id_is_muldiv = 1; issue(); cyc();
    for (int i = 0; i < 6; i++) begin idle(); id_is_muldiv = 1; issue(); cyc(); end

    // D-cache stall masks a mispredict, which is redirected on release.
    for (int i = 0; i < 2; i++) begin
      idle(); dcache_stall = 1; ex_branch_valid = 1; ex_branch_taken = 1;
      ex_branch_target = 32'h200; issue(); cyc();
    end
    idle(); ex_branch_valid = 1; ex_branch_taken = 1; ex_branch_target = 32'h200; issue(); cyc();

    // Saturation: 20 stalled cycles on a 4-bit counter, then clear.
    for (int i = 0; i < 20; i++) begin idle(); icache_stall = 1; issue(); cyc(); end
    idle(); perf_clear = 1; issue(); cyc();
    idle(); issue(); cyc();

    // Reset while a jump redirect is pending drops it.
    idle(); icache_stall = 1; id_jump = 1; id_jump_target = 32'hABC0; issue(); cyc();
    idle(); rst_n = 0; issue(); cyc();
    for (int i = 0; i < 2; i++) begin idle(); issue(); cyc(); end

    // Randomised traffic with a narrow register space to force collisions.
    for (int i = 0; i < 300; i++) begin
      idle();
      rst_n            = ($urandom_range(0, 59) != 0);
      if_id_rs         = 5'($urandom_range(0, 3));
      if_id_rt         = 5'($urandom_range(0, 3));
      id_ex_rt         = 5'($urandom_range(0, 3));
      id_ex_mem_read   = ($urandom_range(0, 2) == 0);
      id_jump          = ($urandom_range(0, 4) == 0);
      id_jump_target   = $urandom;
      id_is_muldiv     = ($urandom_range(0, 4) == 0);
      id_reads_hilo    = ($urandom_range(0, 3) == 0);
      ex_branch_valid  = ($urandom_range(0, 3) == 0);
      id_ex_pred_taken = 1'($urandom_range(0, 1));
      ex_branch_taken  = 1'($urandom_range(0, 1));
      ex_branch_target = $urandom;
      ex_pc_plus4      = $urandom;
      ex_muldiv_start  = ($urandom_range(0, 9) == 0);
      icache_stall     = ($urandom_range(0, 3) == 0);
      dcache_stall     = ($urandom_range(0, 6) == 0);
      perf_clear       = ($urandom_range(0, 29) == 0);
      issue();
      cyc();
    end
    idle();

    // Every queued expectation must have been consumed by the monitor.
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
